nfifo_rr_sched: RTL and testbench

Round-robin read scheduler sharing one output link among N input FIFOs of the network model. Issues single-cycle read strobes to non-empty FIFOs, captures their registered read data one cycle later, and forwards flits downstream through a 2-entry output buffer with valid/ready handshake. Optional packet mode holds the grant on one FIFO until a tail flit passes, so packets are never interleaved on the shared link.

---
 rtl/nfifo_rr_sched_pkg.sv | 33 +++
 rtl/nfifo_rr_sched_arbiter.sv | 45 ++++
 rtl/nfifo_rr_sched.sv | 184 ++++++++++++++++++
 tb/tb_nfifo_rr_sched.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfifo_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : nfifo_sched_pkg
//  Description : Shared state encodings and sizing helpers for the
//                round-robin FIFO read scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package nfifo_sched_pkg;

    // Scheduler state: free arbitration or locked onto one FIFO mid-packet.
    typedef logic [0:0] state_t;
    localparam state_t ST_ARB  = 1'b0;
    localparam state_t ST_LOCK = 1'b1;

    // Bit position that marks the last flit of a packet.
    function automatic int tail_bit(input int w);
        return w - 1;
    endfunction

    // Index width needed to name one of n ports (never below one bit).
    function automatic int idx_width(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nfifo_rr_sched_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nrr_arbiter
//  Description : Combinational N-way round-robin select. Searches the
//                request vector starting one past the pointer, wrapping,
//                and returns a one-hot grant plus the granted index.
//  Revision    : 1.0 - initial release
// ============================================================================
module nrr_arbiter
    import nfifo_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] w_k;

    // Walk the ports cyclically from ptr+1; the first requester wins.
    always_comb begin
        w_k   = ptr_i;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (w_k == IW'(N - 1)) begin
                w_k = '0;
            end else begin
                w_k = w_k + IW'(1);
            end
            if (!any_o && req_i[w_k]) begin
                any_o      = 1'b1;
                idx_o      = w_k;
                gnt_o[w_k] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nfifo_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : nfifo_rr_sched
//  Description : Round-robin read scheduler sharing one output link among
//                N input FIFOs. Issues single-cycle read strobes, captures
//                the registered FIFO data one cycle later into a 2-entry
//                output buffer, and optionally locks onto one FIFO until a
//                tail flit passes so packets never interleave.
//  Revision    : 1.0 - initial release
// ============================================================================
module nfifo_rr_sched
    import nfifo_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int width    = 32,
    parameter int PKT_MODE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N-1:0]            fifo_empty_i,
    output logic [N-1:0]            fifo_read_o,
    input  logic [N*width-1:0]      fifo_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [width-1:0]        out_data_o,
    output logic [idx_width(N)-1:0] out_src_o
);

    localparam int c_IW   = idx_width(N);
    localparam int c_TAIL = tail_bit(width);

    // Registered state
    logic [1:0]       occ_q,   occ_d;
    logic             pend_q,  pend_d;
    logic [c_IW-1:0]  sel_q,   sel_d;
    logic [c_IW-1:0]  ptr_q,   ptr_d;
    state_t           state_q, state_d;
    logic [width-1:0] buf0_q,  buf0_d;
    logic [width-1:0] buf1_q,  buf1_d;
    logic [c_IW-1:0]  src0_q,  src0_d;
    logic [c_IW-1:0]  src1_q,  src1_d;

    // Combinational helpers
    logic [width-1:0] w_cap_data;
    logic             w_cap_tail;
    logic             w_arb;
    logic [N-1:0]     w_req;
    logic [N-1:0]     w_gnt;
    logic [c_IW-1:0]  w_idx;
    logic             w_any;
    logic             w_pop;
    logic [2:0]       w_level;
    logic             w_room;
    logic             w_issue;

    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = buf0_q;
    assign out_src_o   = src0_q;
    assign w_pop       = out_valid_o & out_ready_i;

    // Select the read data of the FIFO strobed last cycle.
    always_comb begin
        w_cap_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_q == c_IW'(k)) begin
                w_cap_data = fifo_data_i[k*width +: width];
            end
        end
    end

    // A tail arriving this cycle releases the lock immediately, so this
    // cycle already arbitrates freely.
    assign w_cap_tail = pend_q & w_cap_data[c_TAIL] & (PKT_MODE != 0);
    assign w_arb      = (state_q == ST_ARB) | w_cap_tail;

    // Build the eligible request set: all non-empty ports, or only the
    // locked port while a packet is in flight.
    always_comb begin
        w_req = '0;
        if (w_arb) begin
            w_req = ~fifo_empty_i;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (sel_q == c_IW'(k)) begin
                    w_req[k] = ~fifo_empty_i[k];
                end
            end
        end
    end

    nrr_arbiter #(
        .N  (N),
        .IW (c_IW)
    ) u_arb (
        .req_i (w_req),
        .ptr_i (ptr_q),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    // Only strobe if the flit will still fit once it lands next cycle.
    assign w_level     = {1'b0, occ_q} + {2'b00, pend_q};
    assign w_room      = (w_level < (3'd2 + {2'b00, w_pop}));
    assign w_issue     = ~rst_i & w_room & w_any;
    assign fifo_read_o = {N{w_issue}} & w_gnt;

    // Next-state for arbitration, lock FSM and the 2-entry output buffer.
    always_comb begin
        pend_d  = w_issue;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        state_d = state_q;
        occ_d   = occ_q + {1'b0, pend_q} - {1'b0, w_pop};
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        src0_d  = src0_q;
        src1_d  = src1_q;

        if (w_issue) begin
            sel_d = w_idx;
            ptr_d = w_idx;
        end

        if (PKT_MODE != 0) begin
            if (w_issue) begin
                state_d = ST_LOCK;
            end else if (w_cap_tail) begin
                state_d = ST_ARB;
            end
        end else begin
            state_d = ST_ARB;
        end

        if (w_pop) begin
            buf0_d = buf1_q;
            src0_d = src1_q;
            if (pend_q) begin
                if (occ_q == 2'd2) begin
                    buf1_d = w_cap_data;
                    src1_d = sel_q;
                end else begin
                    buf0_d = w_cap_data;
                    src0_d = sel_q;
                end
            end
        end else if (pend_q) begin
            if (occ_q == 2'd0) begin
                buf0_d = w_cap_data;
                src0_d = sel_q;
            end else begin
                buf1_d = w_cap_data;
                src1_d = sel_q;
            end
        end
    end

    // State registers; reset drops any pending read and buffered flits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q   <= 2'd0;
            pend_q  <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= c_IW'(N - 1);
            state_q <= ST_ARB;
            buf0_q  <= '0;
            buf1_q  <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
        end else begin
            occ_q   <= occ_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            state_q <= state_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nfifo_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nfifo_rr_sched
//  Description : Directed self-checking bench. Instance 0 runs per-flit
//                arbitration, instance 1 runs packet mode; each has its own
//                behavioural FIFO bank with registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nfifo_rr_sched;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst    = 1'b1;
    logic           ready0 = 1'b0;
    logic           ready1 = 1'b0;
    logic [N-1:0]   empty0, empty1, read0, read1;
    logic [N*W-1:0] fdata0, fdata1;
    logic           valid0, valid1;
    logic [W-1:0]   data0, data1;
    logic [1:0]     src0, src1;

    int checks   = 0;
    int failures = 0;

    nfifo_rr_sched #(.N(N), .width(W), .PKT_MODE(0)) dut0 (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_empty_i (empty0),
        .fifo_read_o  (read0),
        .fifo_data_i  (fdata0),
        .out_valid_o  (valid0),
        .out_ready_i  (ready0),
        .out_data_o   (data0),
        .out_src_o    (src0)
    );

    nfifo_rr_sched #(.N(N), .width(W), .PKT_MODE(1)) dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_empty_i (empty1),
        .fifo_read_o  (read1),
        .fifo_data_i  (fdata1),
        .out_valid_o  (valid1),
        .out_ready_i  (ready1),
        .out_data_o   (data1),
        .out_src_o    (src1)
    );

    // Behavioural FIFO banks: wr advanced by stimulus, head by reads.
    logic [W-1:0] mem   [2][N][64];
    int           wr    [2][N] = '{default: 0};
    int           head  [2][N] = '{default: 0};
    logic [W-1:0] rdata [2][N] = '{default: '0};
    int           bad_rd = 0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                if ((d == 0) ? read0[k] : read1[k]) begin
                    if (wr[d][k] == head[d][k]) begin
                        bad_rd <= bad_rd + 1;
                    end else begin
                        rdata[d][k] <= mem[d][k][head[d][k] % 64];
                        head[d][k]  <= head[d][k] + 1;
                    end
                end
            end
        end
        if ($countones(read0) > 1 || $countones(read1) > 1) begin
            bad_rd <= bad_rd + 1;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            empty0[k]          = (wr[0][k] == head[0][k]);
            empty1[k]          = (wr[1][k] == head[1][k]);
            fdata0[k*W +: W]   = rdata[0][k];
            fdata1[k*W +: W]   = rdata[1][k];
        end
    end

    function automatic logic [W-1:0] mk(input int p, input int s, input bit t);
        return {t, 11'd0, 4'(p), 16'(s)};
    endfunction

    task automatic push(input int d, input int k, input logic [W-1:0] v);
        mem[d][k][wr[d][k] % 64] = v;
        wr[d][k] = wr[d][k] + 1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < N; k++) begin
                push(0, k, mk(k, s, k == 1));
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (read0 !== 4'b0000) begin
                failures++;
                $display("FAIL reset_read: got %b expected 0000", read0);
            end
            checks++;
            if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid: got %b/%b expected 0/0", valid0, valid1);
            end
            checks++;
            if (data0 !== '0 || src0 !== 2'd0) begin
                failures++;
                $display("FAIL reset_out: got data %h src %0d expected 0/0", data0, src0);
            end
        end
        @(negedge clk);
        rst    = 1'b0;
        ready0 = 1'b1;
        #1;
        checks++;
        if (read0 !== 4'b0001) begin
            failures++;
            $display("FAIL first_strobe: got %b expected 0001", read0);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_rr();
        int n;
        n = 0;
        for (int cyc = 1; cyc < 40 && n < 12; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc < 2) begin
                checks++;
                if (valid0 !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_early_valid: got %b expected 0 at cycle %0d", valid0, cyc);
                end
            end
            if (valid0 === 1'b1 && ready0) begin
                checks++;
                if (cyc != n + 2) begin
                    failures++;
                    $display("FAIL rr_timing[%0d]: got cycle %0d expected %0d", n, cyc, n + 2);
                end
                checks++;
                if (data0 !== mk(n % 4, n / 4, (n % 4) == 1) || src0 !== 2'(n % 4)) begin
                    failures++;
                    $display("FAIL rr_flit[%0d]: got %h src %0d expected %h src %0d",
                             n, data0, src0, mk(n % 4, n / 4, (n % 4) == 1), n % 4);
                end
                n++;
            end
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL rr_count: got %0d expected 12", n);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        int strobes;
        int n;
        logic [W-1:0] ed [4];
        int           es [4];
        ed[0] = mk(0, 10, 0); es[0] = 0;
        ed[1] = mk(1, 10, 0); es[1] = 1;
        ed[2] = mk(0, 11, 0); es[2] = 0;
        ed[3] = mk(1, 11, 0); es[3] = 1;
        strobes = 0;
        @(negedge clk);
        ready0 = 1'b0;
        push(0, 0, mk(0, 10, 0));
        push(0, 0, mk(0, 11, 0));
        push(0, 1, mk(1, 10, 0));
        push(0, 1, mk(1, 11, 0));
        #1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (read0 !== 4'b0000) strobes++;
            if (valid0 === 1'b1) begin
                checks++;
                if (data0 !== mk(0, 10, 0) || src0 !== 2'd0) begin
                    failures++;
                    $display("FAIL bp_hold: got %h src %0d expected %h src 0", data0, src0, mk(0, 10, 0));
                end
            end
        end
        checks++;
        if (strobes != 2) begin
            failures++;
            $display("FAIL bp_strobes: got %0d expected 2", strobes);
        end
        checks++;
        if (valid0 !== 1'b1) begin
            failures++;
            $display("FAIL bp_valid: got %b expected 1", valid0);
        end
        n = 0;
        for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
            @(negedge clk);
            if (cyc == 0) ready0 = 1'b1;
            #1;
            if (valid0 === 1'b1 && ready0) begin
                checks++;
                if (data0 !== ed[n] || src0 !== 2'(es[n])) begin
                    failures++;
                    $display("FAIL bp_flit[%0d]: got %h src %0d expected %h src %0d",
                             n, data0, src0, ed[n], es[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 4 || empty0 !== 4'hF) begin
            failures++;
            $display("FAIL bp_drain: got %0d flits empty %b expected 4 flits empty 1111", n, empty0);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_sparse();
        @(negedge clk);
        @(negedge clk);
        push(0, 3, mk(3, 20, 1));
        ready0 = 1'b1;
        #1;
        checks++;
        if (read0 !== 4'b1000) begin
            failures++;
            $display("FAIL sparse_strobe: got %b expected 1000", read0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid0 !== 1'b0) begin
            failures++;
            $display("FAIL sparse_t1: got valid %b expected 0", valid0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid0 !== 1'b1 || src0 !== 2'd3 || data0 !== mk(3, 20, 1)) begin
            failures++;
            $display("FAIL sparse_t2: got valid %b src %0d data %h expected 1/3/%h",
                     valid0, src0, data0, mk(3, 20, 1));
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid0 !== 1'b0) begin
            failures++;
            $display("FAIL sparse_dup: got valid %b expected 0", valid0);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pkt();
        int n;
        logic [W-1:0] ed [6];
        int           es [6];
        ed[0] = mk(1, 0, 0); es[0] = 1;
        ed[1] = mk(1, 1, 0); es[1] = 1;
        ed[2] = mk(1, 2, 0); es[2] = 1;
        ed[3] = mk(1, 3, 1); es[3] = 1;
        ed[4] = mk(2, 0, 0); es[4] = 2;
        ed[5] = mk(2, 1, 1); es[5] = 2;
        n = 0;
        @(negedge clk);
        ready1 = 1'b1;
        push(1, 1, ed[0]);
        push(1, 1, ed[1]);
        push(1, 2, ed[4]);
        push(1, 2, ed[5]);
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            checks++;
            if (read1[2] !== 1'b0) begin
                failures++;
                $display("FAIL pkt_lock: got read %b expected port 2 idle at cycle %0d", read1, cyc);
            end
            if (valid1 === 1'b1 && n < 6) begin
                checks++;
                if (data1 !== ed[n] || src1 !== 2'(es[n])) begin
                    failures++;
                    $display("FAIL pkt_flit[%0d]: got %h src %0d expected %h src %0d",
                             n, data1, src1, ed[n], es[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 2 || valid1 !== 1'b0 || empty1[2] !== 1'b0) begin
            failures++;
            $display("FAIL pkt_stall: got %0d flits valid %b p2empty %b expected 2/0/0",
                     n, valid1, empty1[2]);
        end
        @(negedge clk);
        push(1, 1, ed[2]);
        push(1, 1, ed[3]);
        for (int cyc = 0; cyc < 30 && n < 6; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (valid1 === 1'b1) begin
                checks++;
                if (data1 !== ed[n] || src1 !== 2'(es[n])) begin
                    failures++;
                    $display("FAIL pkt_flit[%0d]: got %h src %0d expected %h src %0d",
                             n, data1, src1, ed[n], es[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 6 || empty1 !== 4'hF) begin
            failures++;
            $display("FAIL pkt_drain: got %0d flits empty %b expected 6 flits empty 1111", n, empty1);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int n;
        logic [W-1:0] ed [3];
        int           es [3];
        ed[0] = mk(0, 32, 0); es[0] = 0;
        ed[1] = mk(1, 30, 0); es[1] = 1;
        ed[2] = mk(0, 33, 0); es[2] = 0;
        @(negedge clk);
        ready0 = 1'b0;
        for (int s = 30; s < 34; s++) push(0, 0, mk(0, s, 0));
        #1;
        checks++;
        if (read0 !== 4'b0001) begin
            failures++;
            $display("FAIL mid_strobe_a: got %b expected 0001", read0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (read0 !== 4'b0001) begin
            failures++;
            $display("FAIL mid_strobe_b: got %b expected 0001", read0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (valid0 !== 1'b1 || read0 !== 4'b0000) begin
            failures++;
            $display("FAIL mid_full: got valid %b read %b expected 1/0000", valid0, read0);
        end
        rst = 1'b1;
        push(0, 1, mk(1, 30, 0));
        @(negedge clk);
        #1;
        checks++;
        if (valid0 !== 1'b0 || read0 !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset: got valid %b read %b expected 0/0000", valid0, read0);
        end
        @(negedge clk);
        rst    = 1'b0;
        ready0 = 1'b1;
        #1;
        checks++;
        if (read0 !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ptr: got %b expected 0001", read0);
        end
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            @(negedge clk);
            #1;
            if (valid0 === 1'b1) begin
                checks++;
                if (data0 !== ed[n] || src0 !== 2'(es[n])) begin
                    failures++;
                    $display("FAIL mid_flit[%0d]: got %h src %0d expected %h src %0d",
                             n, data0, src0, ed[n], es[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL mid_count: got %0d expected 3", n);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_rr();
        test_backpressure();
        test_sparse();
        test_pkt();
        test_reset_mid();
        @(negedge clk);
        checks++;
        if (bad_rd != 0) begin
            failures++;
            $display("FAIL read_protocol: got %0d bad strobes expected 0", bad_rd);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
